// File: rtl/refill_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// refill_mem_responder_pkg
//   Shared CPU parameter header for the instruction-cache refill path.
//   Holds the default data word and cache line widths, the derived
//   words-per-line / word-offset widths for those defaults, and the state
//   encoding of the refill responder FSM.
// -----------------------------------------------------------------------------
package refill_mem_responder_pkg;

    // Default CPU data word and instruction-cache line widths (bits).
    localparam int CPU_WORD             = 32;
    localparam int CPU_CACHE_LINE_WIDTH = 128;

    // Words per line and the width of a word offset inside a line.
    localparam int CPU_WPL   = CPU_CACHE_LINE_WIDTH / CPU_WORD;
    localparam int CPU_OFF_W = $clog2(CPU_WPL);

    // Refill FSM: accept a request, then alternate ISSUE/WAIT once per word,
    // finally pulse DONE for one cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } refill_state_t;

endpackage

// File: rtl/refill_mem_responder.sv
// -----------------------------------------------------------------------------
// refill_mem_responder
//   Serves instruction-cache line refills from a single-word backing memory.
//   A request is accepted in IDLE; the line is then fetched one word at a
//   time (one outstanding read at most) and assembled into data_from_mem,
//   which is announced with a one-cycle memory_ready pulse.
//
// Optional feature (compile-time macro):
//   REFILL_CRIT_WORD_FIRST_EN - when defined, fetching starts at the word
//     addressed by load_addr and wraps around the line (critical word first);
//     when undefined, fetching always starts at word 0. The assembled line is
//     identical in both builds.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   memory_valid   in   refill request, held high until served
//   load_addr      in   refill byte address, sampled on acceptance only
//   memory_ready   out  one-cycle pulse, data_from_mem holds the line
//   data_from_mem  out  assembled line, word i at [i*WORD +: WORD]
//   mem_rd_en      out  single-word read strobe to backing memory
//   mem_addr       out  word-aligned byte address for mem_rd_en
//   mem_rdata      in   backing-memory read data
//   mem_rvalid     in   mem_rdata valid (latency >= 1 cycle, arbitrary)
// -----------------------------------------------------------------------------
module refill_mem_responder
    import refill_mem_responder_pkg::*;
#(
    parameter int WORD             = CPU_WORD,
    parameter int CACHE_LINE_WIDTH = CPU_CACHE_LINE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        memory_valid,
    input  logic [WORD-1:0]             load_addr,
    output logic                        memory_ready,
    output logic [CACHE_LINE_WIDTH-1:0] data_from_mem,
    output logic                        mem_rd_en,
    output logic [WORD-1:0]             mem_addr,
    input  logic [WORD-1:0]             mem_rdata,
    input  logic                        mem_rvalid
);

    localparam int WPL        = CACHE_LINE_WIDTH / WORD;
    localparam int OFF_W      = $clog2(WPL);
    localparam int CNT_W      = OFF_W + 1;
    localparam int LINE_BYTES = CACHE_LINE_WIDTH / 8;
    localparam int WORD_LSB   = $clog2(WORD / 8);

    // Byte-offset bits inside a line; cleared to form the line base.
    localparam logic [WORD-1:0] LINE_MASK = WORD'(LINE_BYTES - 1);

    refill_state_t               r_state;
    refill_state_t               w_next_state;
    logic [WORD-1:0]             r_base;
    logic [OFF_W-1:0]            r_offset;
    logic [CNT_W-1:0]            r_count;
    logic [CACHE_LINE_WIDTH-1:0] r_line;
    logic [OFF_W-1:0]            w_start_off;
    logic                        w_last_word;

`ifdef REFILL_CRIT_WORD_FIRST_EN
    // Critical word first: begin with the word the requester is waiting on.
    assign w_start_off = load_addr[WORD_LSB +: OFF_W];
`else
    assign w_start_off = '0;
`endif

    // The word being returned now is the last one of the line.
    assign w_last_word = (r_count == CNT_W'(WPL - 1));

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_base   <= '0;
            r_offset <= '0;
            r_count  <= '0;
            // NOTE: the line buffer is an ordinary register bank, not a RAM,
            // so it is cleared on reset to discard any partially built line.
            r_line   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (memory_valid) begin
                        r_base   <= load_addr & ~LINE_MASK;
                        r_offset <= w_start_off;
                        r_count  <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_line[r_offset*WORD +: WORD] <= mem_rdata;
                        r_count  <= r_count + CNT_W'(1);
                        // WPL is a power of two, so the natural wrap of the
                        // offset register is the modulo-WPL wrap-around.
                        r_offset <= r_offset + OFF_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        mem_rd_en    = 1'b0;
        mem_addr     = '0;
        memory_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (memory_valid) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Base has its in-line bits clear, so adding the word offset
                // never carries out of the line.
                mem_rd_en    = 1'b1;
                mem_addr     = r_base + ({{(WORD-OFF_W){1'b0}}, r_offset} << WORD_LSB);
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_next_state = w_last_word ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                // No acceptance here: the requester drops memory_valid in this
                // cycle, so the earliest new request is taken in IDLE next.
                memory_ready = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign data_from_mem = r_line;

endmodule
